// File: rtl/fcs_frame_ctrl.sv
// fcs_frame_ctrl: RMII receive sequencer that finds preamble/SFD, feeds the cksum FCS checker
// and emits one status pulse per frame. Define FCS_CTRL_STATS_EN to build the good/bad counters.
module fcs_frame_ctrl #(
  parameter int MIN_PRE_DIBITS  = 28,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int CK_TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        ck_rst,
  output logic        ck_axiiv,
  output logic [1:0]  ck_axiid,
  input  logic        ck_done,
  input  logic        ck_kill,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [3:0]  frame_err,
  output logic [10:0] byte_count,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam int TW = (CK_TIMEOUT > 1) ? $clog2(CK_TIMEOUT) : 1;

  localparam logic [1:0]    PRE_DIBIT = 2'b10;
  localparam logic [1:0]    SFD_DIBIT = 2'b11;
  localparam logic [5:0]    MIN_PRE   = 6'(MIN_PRE_DIBITS);
  localparam logic [10:0]   MIN_BYTES = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0]   MAX_BYTES = 11'(MAX_FRAME_BYTES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(CK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  localparam int ERR_FCS   = 0;
  localparam int ERR_RUNT  = 1;
  localparam int ERR_GIANT = 2;
  localparam int ERR_ALIGN = 3;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    WAIT_CK,
    REPORT,
    DROP
  } state_t;

  state_t state, state_nxt;

  logic          crsdv_p0;
  logic [1:0]    rxd_p0;
  logic [5:0]    pre_cnt, pre_cnt_nxt;
  logic [1:0]    dibit_cnt, dibit_cnt_nxt;
  logic [10:0]   byte_cnt_nxt;
  logic [3:0]    err, err_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          fwd;
  logic          sfd;
  logic          report_nxt;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

  // Stage p0: input capture; the sequencer decides on the registered dibit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crsdv_p0 <= 1'b0;
    else        crsdv_p0 <= crsdv;
  end

  always_ff @(posedge clk) begin
    rxd_p0 <= rxd;
  end

  always_comb begin
    state_nxt     = state;
    pre_cnt_nxt   = pre_cnt;
    dibit_cnt_nxt = dibit_cnt;
    byte_cnt_nxt  = byte_count;
    err_nxt       = err;
    tmo_cnt_nxt   = tmo_cnt;
    fwd           = 1'b0;
    sfd           = 1'b0;
    case (state)
      // REPORT behaves like IDLE so a preamble can follow a report immediately
      IDLE, REPORT: begin
        state_nxt = IDLE;
        if (crsdv_p0 && rxd_p0 == PRE_DIBIT) begin
          state_nxt   = PRE;
          pre_cnt_nxt = 6'd1;
          err_nxt     = 4'd0;
        end
      end
      PRE: begin
        if (!crsdv_p0) begin
          state_nxt = IDLE;
        end else if (rxd_p0 == PRE_DIBIT) begin
          pre_cnt_nxt = sat_inc6(pre_cnt);
        end else if (rxd_p0 == SFD_DIBIT && pre_cnt >= MIN_PRE) begin
          state_nxt     = DATA;
          sfd           = 1'b1;
          dibit_cnt_nxt = 2'd0;
          byte_cnt_nxt  = 11'd0;
          err_nxt       = 4'd0;
        end else begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (!crsdv_p0) begin
          state_nxt   = WAIT_CK;
          tmo_cnt_nxt = '0;
          if (byte_count < MIN_BYTES) err_nxt[ERR_RUNT]  = 1'b1;
          if (dibit_cnt != 2'd0)      err_nxt[ERR_ALIGN] = 1'b1;
        end else if (byte_count == MAX_BYTES) begin
          // this dibit would start a byte beyond the maximum
          state_nxt          = DROP;
          err_nxt[ERR_GIANT] = 1'b1;
        end else begin
          fwd           = 1'b1;
          dibit_cnt_nxt = dibit_cnt + 2'd1;
          if (dibit_cnt == 2'd3) byte_cnt_nxt = byte_count + 11'd1;
        end
      end
      WAIT_CK: begin
        if (ck_done) begin
          state_nxt        = REPORT;
          err_nxt[ERR_FCS] = err[ERR_FCS] | ck_kill;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt        = REPORT;
          err_nxt[ERR_FCS] = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_ONE;
        end
      end
      DROP: begin
        if (!crsdv_p0) state_nxt = err[ERR_GIANT] ? REPORT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign report_nxt = (state_nxt == REPORT);

  // Stage p1: sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre_cnt    <= 6'd0;
      dibit_cnt  <= 2'd0;
      byte_count <= 11'd0;
      err        <= 4'd0;
      tmo_cnt    <= '0;
      ck_rst     <= 1'b1;
      ck_axiiv   <= 1'b0;
      ck_axiid   <= 2'd0;
      axiov      <= 1'b0;
      axiod      <= 2'd0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 4'd0;
    end else begin
      state      <= state_nxt;
      pre_cnt    <= pre_cnt_nxt;
      dibit_cnt  <= dibit_cnt_nxt;
      byte_count <= byte_cnt_nxt;
      err        <= err_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      ck_rst     <= sfd;
      ck_axiiv   <= fwd;
      ck_axiid   <= fwd ? rxd_p0 : 2'd0;
      axiov      <= fwd;
      axiod      <= fwd ? rxd_p0 : 2'd0;
      frame_done <= report_nxt;
      frame_ok   <= report_nxt && (err_nxt == 4'd0);
      frame_err  <= report_nxt ? err_nxt : 4'd0;
    end
  end

`ifdef FCS_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p2: statistics follow the status pulse by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else if (frame_done) begin
      if (frame_ok) good_cnt <= sat_inc16(good_cnt);
      else          bad_cnt  <= sat_inc16(bad_cnt);
    end
  end
`else
  assign good_cnt = 16'd0;
  assign bad_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_fcs_frame_ctrl.sv
// Directed bench for fcs_frame_ctrl: scoreboard queues for forwarded dibits and frame status.
`timescale 1ns/1ps
module tb_fcs_frame_ctrl;

  localparam int MIN_PRE = 28;
  localparam int MIN_B   = 64;
  localparam int MAX_B   = 1518;
  localparam int TMO     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crsdv = 1'b0;
  logic [1:0]  rxd = 2'b00;
  logic        ck_done = 1'b0;
  logic        ck_kill = 1'b0;
  logic        ck_rst, ck_axiiv, axiov, frame_done, frame_ok;
  logic [1:0]  ck_axiid, axiod;
  logic [3:0]  frame_err;
  logic [10:0] byte_count;
  logic [15:0] good_cnt, bad_cnt;

  fcs_frame_ctrl #(
    .MIN_PRE_DIBITS (MIN_PRE),
    .MIN_FRAME_BYTES(MIN_B),
    .MAX_FRAME_BYTES(MAX_B),
    .CK_TIMEOUT     (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .crsdv     (crsdv),
    .rxd       (rxd),
    .ck_rst    (ck_rst),
    .ck_axiiv  (ck_axiiv),
    .ck_axiid  (ck_axiid),
    .ck_done   (ck_done),
    .ck_kill   (ck_kill),
    .axiov     (axiov),
    .axiod     (axiod),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .byte_count(byte_count),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic [3:0]  err;
    logic [10:0] bc;
  } status_t;

  status_t    stat_q[$];
  logic [1:0] dib_q[$];
  int checks = 0;
  int failures = 0;
  int ckrst_seen = 0;
  int exp_ckrst = 0;
  int exp_good = 0;
  int exp_bad = 0;
  logic rst_prev = 1'b0;
  logic done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops scoreboards as the DUT produces data and status
  always @(negedge clk) begin
    logic [1:0] exp_d;
    status_t    s;
    if (rst_n) begin
      check("ck_mirror_v", 32'(ck_axiiv), 32'(axiov));
      check("ck_mirror_d", 32'(ck_axiid), 32'(axiod));
      if (axiov) begin
        check("dibit_q_nonempty", 32'(dib_q.size() != 0), 32'd1);
        if (dib_q.size() != 0) begin
          exp_d = dib_q.pop_front();
          check("dibit", 32'(axiod), 32'(exp_d));
        end
      end
      if (frame_done) begin
        check("done_single", 32'(done_prev), 32'd0);
        check("status_q_nonempty", 32'(stat_q.size() != 0), 32'd1);
        if (stat_q.size() != 0) begin
          s = stat_q.pop_front();
          check("frame_ok", 32'(frame_ok), 32'(s.ok));
          check("frame_err", 32'(frame_err), 32'(s.err));
          check("byte_count", 32'(byte_count), 32'(s.bc));
        end
      end
      if (ck_rst && rst_prev) ckrst_seen++;
    end
    rst_prev  = rst_n;
    done_prev = frame_done;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic put(input logic c, input logic [1:0] d);
    crsdv = c;
    rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 2'b00);
  endtask

  task automatic check_stats();
`ifdef FCS_CTRL_STATS_EN
    check("good_cnt", 32'(good_cnt), 32'(exp_good));
    check("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
`else
    check("good_cnt", 32'(good_cnt), 32'd0);
    check("bad_cnt", 32'(bad_cnt), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ck_rst"}, 32'(ck_rst), 32'd1);
    check({tag, "_ck_axiiv"}, 32'(ck_axiiv), 32'd0);
    check({tag, "_ck_axiid"}, 32'(ck_axiid), 32'd0);
    check({tag, "_axiov"}, 32'(axiov), 32'd0);
    check({tag, "_axiod"}, 32'(axiod), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    check({tag, "_good_cnt"}, 32'(good_cnt), 32'd0);
    check({tag, "_bad_cnt"}, 32'(bad_cnt), 32'd0);
  endtask

  // ck_mode: 0 = ck_done clean, 1 = ck_done with kill, 2 = no ck_done
  task automatic send_frame(input int pre_n, input int nbytes, input int extra,
                            input int ck_mode, input bit stray, input int gap);
    int         total;
    int         cyc;
    bit         accept;
    bit         giant;
    status_t    s;
    logic [1:0] d;
    total  = nbytes * 4 + extra;
    accept = (pre_n >= MIN_PRE);
    giant  = (total > MAX_B * 4);
    for (int i = 0; i < pre_n; i++) put(1'b1, 2'b10);
    put(1'b1, 2'b11);
    if (accept) exp_ckrst++;
    for (int i = 0; i < total; i++) begin
      d = 2'($urandom_range(0, 3));
      if (accept && i < MAX_B * 4) dib_q.push_back(d);
      if (stray && i == 40) begin
        ck_done = 1'b1;
        ck_kill = 1'b1;
      end
      put(1'b1, d);
      ck_done = 1'b0;
      ck_kill = 1'b0;
    end
    if (accept) begin
      s.err = 4'd0;
      if (giant) begin
        s.err[2] = 1'b1;
        s.bc     = 11'(MAX_B);
      end else begin
        s.bc     = 11'(total / 4);
        s.err[0] = (ck_mode != 0);
        s.err[1] = ((total / 4) < MIN_B);
        s.err[3] = ((total % 4) != 0);
      end
      s.ok = (s.err == 4'd0);
      stat_q.push_back(s);
      if (s.ok) exp_good++;
      else      exp_bad++;
    end
    put(1'b0, 2'b00);
    if (accept && !giant && ck_mode != 2) begin
      @(posedge clk);
      #1;
      ck_done = 1'b1;
      ck_kill = (ck_mode == 1);
      @(posedge clk);
      #1;
      ck_done = 1'b0;
      ck_kill = 1'b0;
      check("done_latency", 32'(frame_done), 32'd1);
    end else if (accept) begin
      cyc = 0;
      while (frame_done !== 1'b1 && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check("done_seen", 32'(frame_done), 32'd1);
      if (!giant) check("timeout_window", 32'(cyc >= TMO && cyc <= TMO + 2), 32'd1);
    end else begin
      idle(3);
    end
    if (gap > 0) idle(gap);
    if (gap >= 2) check_stats();
  endtask

  initial begin
    logic [1:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ck_rst_release", 32'(ck_rst), 32'd0);
    idle(3);

    send_frame(31, 64, 0, 0, 1'b1, 4);
    send_frame(31, 64, 0, 1, 1'b0, 4);
    send_frame(31, 20, 0, 0, 1'b0, 0);
    send_frame(31, 64, 2, 0, 1'b0, 4);
    send_frame(10, 64, 0, 0, 1'b0, 4);

    for (int i = 0; i < 15; i++) put(1'b1, 2'b10);
    put(1'b1, 2'b00);
    for (int i = 0; i < 20; i++) put(1'b1, 2'b10);
    put(1'b1, 2'b11);
    for (int i = 0; i < 40; i++) put(1'b1, 2'($urandom_range(0, 3)));
    idle(6);
    check("drop_no_status", 32'(stat_q.size()), 32'd0);

    send_frame(31, 64, 0, 0, 1'b0, 4);
    send_frame(70, 64, 0, 0, 1'b0, 4);
    send_frame(31, 1600, 0, 2, 1'b0, 4);
    send_frame(31, 64, 0, 2, 1'b0, 4);

    for (int i = 0; i < 31; i++) put(1'b1, 2'b10);
    put(1'b1, 2'b11);
    exp_ckrst++;
    for (int i = 0; i < 30 * 4; i++) begin
      d = 2'($urandom_range(0, 3));
      dib_q.push_back(d);
      put(1'b1, d);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    dib_q.delete();
    exp_good = 0;
    exp_bad  = 0;
    idle(2);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ck_rst_release2", 32'(ck_rst), 32'd0);
    idle(3);

    send_frame(31, 64, 0, 0, 1'b0, 4);

    check("dibit_q_empty", 32'(dib_q.size()), 32'd0);
    check("status_q_empty", 32'(stat_q.size()), 32'd0);
    check("ck_rst_pulses", 32'(ckrst_seen), 32'(exp_ckrst));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
